// File: rtl/fusion_accumulator.sv
// Unpacks 64-bit packed products from the bit-fusion multiplier into 1/2/4 lanes and
// accumulates each lane over a dot product. Optional clamping via FUSION_ACC_SAT_EN.
module fusion_accumulator #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           cfga,
  input  logic [1:0]           cfgb,
  input  logic                 sgn,
  input  logic [LEN_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*ACC_W-1:0]   out_data,
  output logic [2:0]           out_lanes,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] count;
  logic             sgn_q;
  logic [ACC_W-1:0] acc     [4];
  logic [ACC_W-1:0] field   [4];
  logic [ACC_W-1:0] acc_nxt [4];

  function automatic logic [ACC_W-1:0] ext16(input logic [15:0] d, input logic s);
    return {{(ACC_W-16){s & d[15]}}, d};
  endfunction

  function automatic logic [ACC_W-1:0] ext12(input logic [11:0] d, input logic s);
    return {{(ACC_W-12){s & d[11]}}, d};
  endfunction

  function automatic logic [2:0] lane_count(input logic [3:0] cfg);
    case (cfg)
      4'b1010:          return 3'd1;
      4'b1001, 4'b0110: return 3'd2;
      default:          return 3'd4;
    endcase
  endfunction

  // The latched lane count doubles as the latched precision configuration.
  always_comb begin
    for (int k = 0; k < 4; k++) field[k] = '0;
    case (out_lanes)
      3'd1: field[0] = ext16(in_data[15:0], sgn_q);
      3'd2: begin
        field[0] = ext12(in_data[11:0], sgn_q);
        field[1] = ext12(in_data[43:32], sgn_q);
      end
      3'd4: begin
        field[0] = ext16(in_data[15:0], sgn_q);
        field[1] = ext16(in_data[31:16], sgn_q);
        field[2] = ext16(in_data[47:32], sgn_q);
        field[3] = ext16(in_data[63:48], sgn_q);
      end
      default: ;
    endcase
  end

`ifdef FUSION_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum     [4];
  logic [3:0]     sat_q;
  logic [3:0]     sat_nxt;

  // Once a lane clamps it stays clamped until the next start clears it.
  always_comb begin
    sat_nxt = sat_q;
    for (int k = 0; k < 4; k++) begin
      sum[k]     = {1'b0, acc[k]} + {1'b0, field[k]};
      acc_nxt[k] = sum[k][ACC_W-1:0];
      if (sat_q[k]) begin
        acc_nxt[k] = acc[k];
      end else if (sgn_q) begin
        if ((acc[k][ACC_W-1] == field[k][ACC_W-1]) && (sum[k][ACC_W-1] != acc[k][ACC_W-1])) begin
          acc_nxt[k] = acc[k][ACC_W-1] ? SMIN : SMAX;
          sat_nxt[k] = 1'b1;
        end
      end else if (sum[k][ACC_W]) begin
        acc_nxt[k] = '1;
        sat_nxt[k] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < 4; k++) acc_nxt[k] = acc[k] + field[k];
  end
`endif

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 4; k++) out_data[k*ACC_W +: ACC_W] = acc[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      sgn_q     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_lanes <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      for (int k = 0; k < 4; k++) acc[k] <= '0;
`ifdef FUSION_ACC_SAT_EN
      sat_q     <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfga == 2'b11 || cfgb == 2'b11) begin
              err <= 1'b1;
            end else begin
              sgn_q     <= sgn;
              out_lanes <= lane_count({cfga, cfgb});
              busy      <= 1'b1;
              count     <= len;
              for (int k = 0; k < 4; k++) acc[k] <= '0;
`ifdef FUSION_ACC_SAT_EN
              sat_q     <= '0;
`endif
              if (len == '0) begin
                state     <= DRAIN;
                out_valid <= 1'b1;
              end else begin
                state    <= ACCUM;
                in_ready <= 1'b1;
              end
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            for (int k = 0; k < 4; k++) acc[k] <= acc_nxt[k];
`ifdef FUSION_ACC_SAT_EN
            sat_q <= sat_nxt;
`endif
            count <= count - LEN_ONE;
            if (count == LEN_ONE) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fusion_accumulator.sv
// Directed self-checking bench for fusion_accumulator (32-bit lanes plus a 17-bit
// instance for the wrap/saturate boundary; expectation follows FUSION_ACC_SAT_EN).
module tb_fusion_accumulator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, start_b;
  logic [1:0]   cfga, cfgb;
  logic         sgn;
  logic [7:0]   len;
  logic         in_valid, in_valid_b;
  logic         in_ready, in_ready_b;
  logic [63:0]  in_data;
  logic         out_valid, out_valid_b;
  logic         out_ready, out_ready_b;
  logic [127:0] out_data;
  logic [67:0]  out_data_b;
  logic [2:0]   out_lanes, out_lanes_b;
  logic         busy, busy_b;
  logic         err, err_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fusion_accumulator #(.ACC_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfga(cfga), .cfgb(cfgb), .sgn(sgn),
    .len(len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lanes(out_lanes), .busy(busy), .err(err)
  );

  fusion_accumulator #(.ACC_W(17), .LEN_W(8)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cfga(cfga), .cfgb(cfgb), .sgn(sgn),
    .len(len), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_lanes(out_lanes_b), .busy(busy_b), .err(err_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic begin_dot(input logic [1:0] a, input logic [1:0] b, input logic s,
                           input logic [7:0] n);
    cfga = a; cfgb = b; sgn = s; len = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0; cfga = 2'b00; cfgb = 2'b00;
    sgn = 1'b0; len = '0; in_valid = 1'b0; in_valid_b = 1'b0; in_data = '0;
    out_ready = 1'b0; out_ready_b = 1'b0;
    step(); step();
    check_output("reset in_ready", 128'(in_ready), 128'd0);
    check_output("reset out_valid", 128'(out_valid), 128'd0);
    check_output("reset out_data", out_data, 128'd0);
    check_output("reset out_lanes", 128'(out_lanes), 128'd0);
    check_output("reset busy", 128'(busy), 128'd0);
    check_output("reset err", 128'(err), 128'd0);
    rst_n = 1'b1;
    step();

    // 8x8 signed, one lane, -10 three times; upper bits are junk
    begin_dot(2'b10, 2'b10, 1'b1, 8'd3);
    check_output("t1 in_ready", 128'(in_ready), 128'd1);
    check_output("t1 busy", 128'(busy), 128'd1);
    check_output("t1 out_lanes", 128'(out_lanes), 128'd1);
    in_valid = 1'b1; in_data = 64'h1234_5678_9ABC_FFF6;
    step(); step();
    check_output("t1 out_valid early", 128'(out_valid), 128'd0);
    step();
    in_valid = 1'b0;
    check_output("t1 out_valid", 128'(out_valid), 128'd1);
    check_output("t1 in_ready drain", 128'(in_ready), 128'd0);
    check_output("t1 out_data", out_data, {96'd0, 32'hFFFF_FFE2});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_output("t1 out_valid after accept", 128'(out_valid), 128'd0);
    check_output("t1 busy after accept", 128'(busy), 128'd0);

    // 8x4 unsigned, two 12-bit lanes
    begin_dot(2'b10, 2'b01, 1'b0, 8'd2);
    in_valid = 1'b1; in_data = 64'hABCD_F010_5555_A0FF;
    step(); step();
    in_valid = 1'b0;
    check_output("t2 out_valid", 128'(out_valid), 128'd1);
    check_output("t2 out_lanes", 128'(out_lanes), 128'd2);
    check_output("t2 out_data", out_data, {64'd0, 32'h0000_0020, 32'h0000_01FE});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 4x4 signed, four lanes, with an idle gap before the only beat
    begin_dot(2'b01, 2'b01, 1'b1, 8'd1);
    step();
    check_output("t3 gap out_valid", 128'(out_valid), 128'd0);
    in_valid = 1'b1; in_data = 64'h8000_0001_7FFF_FFFF;
    step();
    in_valid = 1'b0;
    check_output("t3 out_valid", 128'(out_valid), 128'd1);
    check_output("t3 out_lanes", 128'(out_lanes), 128'd4);
    check_output("t3 out_data", out_data,
                 {32'hFFFF_8000, 32'h0000_0001, 32'h0000_7FFF, 32'hFFFF_FFFF});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // len=0 goes straight to DRAIN with cleared sums; stall, and ignore start there
    begin_dot(2'b10, 2'b10, 1'b0, 8'd0);
    check_output("t4 out_valid", 128'(out_valid), 128'd1);
    check_output("t4 in_ready", 128'(in_ready), 128'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cfga = 2'b11; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      check_output($sformatf("t4 hold valid %0d", i), 128'(out_valid), 128'd1);
      check_output($sformatf("t4 hold data %0d", i), out_data, 128'd0);
      check_output($sformatf("t4 hold err %0d", i), 128'(err), 128'd0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_output("t4 out_valid after accept", 128'(out_valid), 128'd0);
    check_output("t4 busy after accept", 128'(busy), 128'd0);

    // illegal cfg pulses err for exactly one cycle
    begin_dot(2'b11, 2'b10, 1'b0, 8'd2);
    check_output("t5 err pulse", 128'(err), 128'd1);
    check_output("t5 busy", 128'(busy), 128'd0);
    step();
    check_output("t5 err cleared", 128'(err), 128'd0);
    check_output("t5 in_ready", 128'(in_ready), 128'd0);

    // asynchronous reset in the middle of accumulation
    begin_dot(2'b10, 2'b10, 1'b0, 8'd4);
    in_valid = 1'b1; in_data = 64'h0000_0000_0000_0005;
    step(); step();
    check_output("t6 partial sum", out_data, 128'd10);
    rst_n = 1'b0;
    #1;
    check_output("t6 rst in_ready", 128'(in_ready), 128'd0);
    check_output("t6 rst out_data", out_data, 128'd0);
    check_output("t6 rst out_lanes", 128'(out_lanes), 128'd0);
    check_output("t6 rst busy", 128'(busy), 128'd0);
    check_output("t6 rst out_valid", 128'(out_valid), 128'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // 17-bit lanes: +0x7FFF three times overflows the signed range
    cfga = 2'b10; cfgb = 2'b10; sgn = 1'b1; len = 8'd3; start_b = 1'b1;
    step();
    start_b = 1'b0;
    in_valid_b = 1'b1; in_data = 64'h0000_0000_0000_7FFF;
    step(); step(); step();
    in_valid_b = 1'b0;
    check_output("t7 out_valid", 128'(out_valid_b), 128'd1);
`ifdef FUSION_ACC_SAT_EN
    check_output("t7 out_data sat", 128'(out_data_b), {60'd0, 51'd0, 17'h0FFFF});
`else
    check_output("t7 out_data wrap", 128'(out_data_b), {60'd0, 51'd0, 17'h17FFD});
`endif
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
    check_output("t7 busy after accept", 128'(busy_b), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
